// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads instruction memory
// combinationally and buffers {pc, instr} pairs in a circular fetch queue for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [31:0]                     imem_pc,
  input  logic [31:0]                     imem_instr,
  input  logic                            redirect_valid,
  input  logic [31:0]                     redirect_pc,
  output logic                            if_valid,
  input  logic                            if_ready,
  output logic [31:0]                     if_instr,
  output logic [31:0]                     if_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t        fq_mem [FQ_DEPTH];
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  fq_entry_t        head;

  // Handshake and push decisions; redirect suppresses both.
  always_comb begin
    if_valid = (count != '0) && !redirect_valid;
    pop      = if_valid && if_ready;
    push     = !redirect_valid && ((count < CNT_W'(FQ_DEPTH)) || pop);
    head     = fq_mem[rd_ptr];
    if_instr = if_valid ? head.instr : NOP;
    if_pc    = if_valid ? head.pc : 32'h0;
    imem_pc  = fetch_pc;
    fq_count = count;
  end

  // Pointers, occupancy and fetch PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      fq_mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_instr};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-based reference model
// of the fetch front end, plus directed scenarios for reset, stall, redirect and PC wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [2:0]  fq_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [31:0] m_pc;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16) return 32'h00FF1025;
    if (a == 32'h14) return 32'h123452B7;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
  endfunction

  always_comb imem_instr = mem_word(imem_pc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic rv);
    logic exp_v;
    exp_v = (q_pc.size() != 0) && !rv && reset;
    chk("if_valid", 32'(if_valid), 32'(exp_v));
    chk("if_instr", if_instr, exp_v ? q_in[0] : NOP);
    chk("if_pc",    if_pc,    exp_v ? q_pc[0] : 32'h0);
    chk("fq_count", 32'(fq_count), 32'(q_pc.size()));
    chk("imem_pc",  imem_pc,  m_pc);
  endtask

  // Called at a falling edge: drive, check, advance model, move to next falling edge.
  task automatic step(input logic rv, input logic [31:0] rp, input logic rdy);
    logic exp_v;
    redirect_valid = rv;
    redirect_pc    = rp;
    if_ready       = rdy;
    #1;
    check_outputs(rv);
    exp_v = (q_pc.size() != 0) && !rv;
    if (rv) begin
      q_pc.delete();
      q_in.delete();
      m_pc = rp & 32'hFFFF_FFFC;
    end else begin
      if (exp_v && rdy) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (q_pc.size() < FQ_DEPTH) begin
        q_pc.push_back(m_pc);
        q_in.push_back(mem_word(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle, check immediate clearing, release at the next falling edge.
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    q_pc.delete();
    q_in.delete();
    m_pc = RESET_PC;
    check_outputs(redirect_valid);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    m_pc           = RESET_PC;
    repeat (2) @(negedge clk);
    check_outputs(1'b0);
    reset = 1'b1;

    // Streaming from reset with decode always ready
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // Stall until full, then steady pop+push
    reset_pulse();
    repeat (6) step(1'b0, 32'h0, 1'b0);
    chk("full_count", 32'(fq_count), 32'd4);
    chk("full_pc_held", imem_pc, 32'd16);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    // Redirect with three entries queued
    reset_pulse();
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h14, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect target
    step(1'b1, 32'h17, 1'b1);
    chk("misalign_pc", imem_pc, 32'h14);
    repeat (3) step(1'b0, 32'h0, 1'b1);

    // PC wrap at top of address space
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Reset mid-stream with two entries held
    reset_pulse();
    repeat (2) step(1'b0, 32'h0, 1'b0);
    chk("pre_reset_count", 32'(fq_count), 32'd2);
    reset_pulse();
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_pulse();
      end else begin
        step(($urandom_range(0, 11) == 0), $urandom, 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
